modulo_add_ctrl: RTL

MODULO_ADD_CTRL -- requirements
Module: modulo_add_ctrl

---
 rtl/modulo_add_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/modulo_add_ctrl.sv
// modulo_add_ctrl -- sequencer for an end-around-carry modulo (2^W-1) adder.
//   Drives an external W-bit adder over one or two passes. Pass one adds the
//   operands. If that add carries out, pass two adds 1 to the low W bits.
//   A result of all-ones is congruent to 0 and is reported as 0.
//
// Optional feature, macro MODADD_ACC_EN:
//   Adds the acc_clr port and a W-bit accumulator. Operand A is taken from
//   the accumulator instead of in_a. The accumulator is loaded with out_sum
//   on the DONE handshake, and acc_clr zeroes it while the FSM is in IDLE.
//
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   in_a, in_b          operands (in_a is ignored when MODADD_ACC_EN is set)
//   add_a, add_b        operands to the external adder; 0 when no add is running
//   add_sum             external adder result, W+1 bits, bit W is the carry
//   out_valid/out_ready result handshake
//   out_sum, corr       normalized result and end-around-correction flag
//   busy                high in every state except IDLE
//   acc_clr             (MODADD_ACC_EN only) clear the accumulator in IDLE
module modulo_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W:0]   add_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         corr,
  output logic         busy
`ifdef MODADD_ACC_EN
  ,
  input  logic         acc_clr
`endif
);

  typedef enum logic [1:0] {IDLE, ADD, CORRECT, DONE} state_t;

  state_t       state, nxt;
  logic [W-1:0] op_a, op_b;
  // The carry out of the first pass only steers the FSM, and the correction
  // pass cannot carry again. Only the low W bits of the sum are kept.
  logic [W-1:0] sum;
  logic         corr_r;
  logic [W-1:0] a_src;
  logic [W-1:0] res;

`ifdef MODADD_ACC_EN
  logic [W-1:0] acc;
  // A clear in the same cycle as an accepted operand pair takes effect
  // immediately, so that operation uses A = 0.
  assign a_src = acc_clr ? '0 : acc;
`else
  assign a_src = in_a;
`endif

  // An all-ones value is the second encoding of zero.
  assign res = (&sum) ? '0 : sum;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = ADD;
      ADD:     nxt = add_sum[W] ? CORRECT : DONE;
      CORRECT: nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    add_a     = '0;
    add_b     = '0;
    out_sum   = '0;
    corr      = 1'b0;
    case (state)
      ADD: begin
        add_a = op_a;
        add_b = op_b;
      end
      CORRECT: begin
        add_a = sum;
        add_b = W'(1);
      end
      DONE: begin
        out_sum = res;
        corr    = corr_r;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      sum    <= '0;
      corr_r <= 1'b0;
`ifdef MODADD_ACC_EN
      acc    <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a   <= a_src;
          op_b   <= in_b;
          sum    <= '0;
          corr_r <= 1'b0;
        end
        ADD:     sum <= add_sum[W-1:0];
        CORRECT: begin
          sum    <= add_sum[W-1:0];
          corr_r <= 1'b1;
        end
        default: ;
      endcase
`ifdef MODADD_ACC_EN
      if (state == IDLE && acc_clr)        acc <= '0;
      else if (state == DONE && out_ready) acc <= res;
`endif
    end
  end

endmodule
